// File: rtl/tmr_cap_filt.sv
// Capture-pin conditioner: synchroniser, optional invert, prescaled sampling, consecutive-sample glitch filter.
// Latency STAGE + (div_i+1)*max(flt_i,1) edges worst case; no backpressure, outputs are registered levels/pulses.
module tmr_cap_filt #(
    parameter int STAGE     = 2,
    parameter int DIV_WIDTH = 8,
    parameter int FLT_WIDTH = 4
) (
    input  logic                 clk_i,
    input  logic                 rst_n_i,
    input  logic                 en_i,
    input  logic                 inv_i,
    input  logic [DIV_WIDTH-1:0] div_i,
    input  logic [FLT_WIDTH-1:0] flt_i,
    input  logic                 clr_i,
    input  logic                 raw_i,
    output logic                 dat_o,
    output logic                 rise_o,
    output logic                 fall_o,
    output logic [7:0]           glitch_cnt_o
);

    typedef enum logic {ST_IDLE, ST_CAND} state_t;

    localparam logic [DIV_WIDTH-1:0] DIV_ONE = DIV_WIDTH'(1);
    localparam logic [FLT_WIDTH:0]   FLT_ONE = (FLT_WIDTH + 1)'(1);

    logic [STAGE-1:0]     r_sync;
    logic [DIV_WIDTH-1:0] r_pcnt;
    state_t               r_state;
    logic [FLT_WIDTH-1:0] r_run;
    logic                 r_dat;
    logic                 r_rise;
    logic                 r_fall;
    logic [7:0]           r_gcnt;

    logic                 w_s_in;
    logic                 w_tick;
    logic [FLT_WIDTH:0]   w_flt_eff;
    logic [FLT_WIDTH:0]   w_run_inc;
    state_t               w_state_nxt;
    logic [FLT_WIDTH-1:0] w_run_nxt;
    logic                 w_dat_nxt;
    logic                 w_rise_nxt;
    logic                 w_fall_nxt;
    logic                 w_glitch;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[STAGE-2:0], raw_i};
        end
    end

    assign w_s_in = r_sync[STAGE-1] ^ inv_i;
    // >= rather than == so a div_i lowered below the running count still ticks promptly.
    assign w_tick = en_i && (r_pcnt >= div_i);

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_pcnt <= '0;
        end else if (!en_i || w_tick) begin
            r_pcnt <= '0;
        end else begin
            r_pcnt <= r_pcnt + DIV_ONE;
        end
    end

    assign w_flt_eff = (flt_i == '0) ? FLT_ONE : {1'b0, flt_i};
    assign w_run_inc = {1'b0, r_run} + FLT_ONE;

    always_comb begin
        w_state_nxt = r_state;
        w_run_nxt   = r_run;
        w_dat_nxt   = r_dat;
        w_rise_nxt  = 1'b0;
        w_fall_nxt  = 1'b0;
        w_glitch    = 1'b0;
        if (!en_i) begin
            w_state_nxt = ST_IDLE;
            w_run_nxt   = '0;
        end else if (w_tick) begin
            if (w_s_in == r_dat) begin
                w_glitch    = (r_state == ST_CAND);
                w_state_nxt = ST_IDLE;
                w_run_nxt   = '0;
            end else if (w_run_inc >= w_flt_eff) begin
                w_dat_nxt   = w_s_in;
                w_rise_nxt  = w_s_in;
                w_fall_nxt  = !w_s_in;
                w_state_nxt = ST_IDLE;
                w_run_nxt   = '0;
            end else begin
                // Cannot overflow: run+1 < flt_eff, which fits in FLT_WIDTH bits.
                w_run_nxt   = w_run_inc[FLT_WIDTH-1:0];
                w_state_nxt = ST_CAND;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_state <= ST_IDLE;
            r_run   <= '0;
            r_dat   <= 1'b0;
            r_rise  <= 1'b0;
            r_fall  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_run   <= w_run_nxt;
            r_dat   <= w_dat_nxt;
            r_rise  <= w_rise_nxt;
            r_fall  <= w_fall_nxt;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_gcnt <= '0;
        end else if (clr_i) begin
            r_gcnt <= '0;
        end else if (w_glitch && (r_gcnt != 8'hFF)) begin
            r_gcnt <= r_gcnt + 8'd1;
        end
    end

    assign dat_o        = r_dat;
    assign rise_o       = r_rise;
    assign fall_o       = r_fall;
    assign glitch_cnt_o = r_gcnt;

endmodule
